// File: rtl/csr_access_controller.sv
// Zicsr access sequencer: arbitrates core/debug requests and performs the atomic
// read-modify-write against a CSR file with one combinational read and one write port.
module csr_access_controller #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_req_valid,
    output logic            core_req_ready,
    input  logic [2:0]      core_funct3,
    input  logic [11:0]     core_csr_index,
    input  logic [XLEN-1:0] core_operand,
    input  logic            core_operand_zero,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic            dbg_write,
    input  logic [11:0]     dbg_csr_index,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            rsp_valid,
    output logic            rsp_source,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    output logic            busy,
    output logic            read_enable_csr,
    output logic [11:0]     csr_read_index,
    input  logic [XLEN-1:0] csr_read_data,
    output logic            write_enable_csr,
    output logic [11:0]     csr_write_index,
    output logic [XLEN-1:0] csr_write_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q;
    logic              src_q;
    logic [2:0]        funct3_q;
    logic [11:0]       index_q;
    logic [XLEN-1:0]   operand_q;
    logic [XLEN-1:0]   old_q;
    logic              operand_zero_q;
    logic              dbg_write_q;
    logic              dbg_prio_q;

    logic              grant_core;
    logic              grant_dbg;
    logic [11:0]       sel_index;
    logic [XLEN-1:0]   new_value;
    logic              write_req;
    logic              bad_funct3;
    logic              illegal;

    // dbg_prio_q set means debug wins the next simultaneous request.
    always_comb begin
        grant_dbg  = dbg_req_valid && (!core_req_valid || !ROUND_ROBIN || dbg_prio_q);
        grant_core = core_req_valid && !grant_dbg;
        sel_index  = grant_dbg ? dbg_csr_index : core_csr_index;
    end

    assign core_req_ready = reset && (state_q == StIdle) && grant_core;
    assign dbg_req_ready  = reset && (state_q == StIdle) && grant_dbg;
    assign busy           = (state_q != StIdle);

    always_comb begin
        new_value  = '0;
        write_req  = 1'b0;
        bad_funct3 = 1'b0;
        if (src_q) begin
            new_value = operand_q;
            write_req = dbg_write_q;
        end else begin
            case (funct3_q)
                3'b001, 3'b101: begin
                    new_value = operand_q;
                    write_req = 1'b1;
                end
                3'b010, 3'b110: begin
                    new_value = csr_read_data | operand_q;
                    write_req = !operand_zero_q;
                end
                3'b011, 3'b111: begin
                    new_value = csr_read_data & ~operand_q;
                    write_req = !operand_zero_q;
                end
                default: bad_funct3 = 1'b1;
            endcase
        end
        illegal = bad_funct3 || (write_req && (index_q[11:10] == 2'b11));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            src_q            <= 1'b0;
            funct3_q         <= '0;
            index_q          <= '0;
            operand_q        <= '0;
            old_q            <= '0;
            operand_zero_q   <= 1'b0;
            dbg_write_q      <= 1'b0;
            dbg_prio_q       <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_source       <= 1'b0;
            rsp_rdata        <= '0;
            rsp_illegal      <= 1'b0;
            read_enable_csr  <= 1'b0;
            csr_read_index   <= '0;
            write_enable_csr <= 1'b0;
            csr_write_index  <= '0;
            csr_write_data   <= '0;
        end else begin
            rsp_valid        <= 1'b0;
            rsp_source       <= 1'b0;
            rsp_rdata        <= '0;
            rsp_illegal      <= 1'b0;
            read_enable_csr  <= 1'b0;
            csr_read_index   <= '0;
            write_enable_csr <= 1'b0;
            csr_write_index  <= '0;
            csr_write_data   <= '0;
            case (state_q)
                StIdle: begin
                    if (grant_core || grant_dbg) begin
                        src_q           <= grant_dbg;
                        funct3_q        <= core_funct3;
                        index_q         <= sel_index;
                        operand_q       <= grant_dbg ? dbg_wdata : core_operand;
                        operand_zero_q  <= core_operand_zero;
                        dbg_write_q     <= dbg_write;
                        if (ROUND_ROBIN) begin
                            dbg_prio_q <= grant_core;
                        end
                        read_enable_csr <= 1'b1;
                        csr_read_index  <= sel_index;
                        state_q         <= StRead;
                    end
                end
                StRead: begin
                    old_q <= csr_read_data;
                    if (write_req && !illegal) begin
                        write_enable_csr <= 1'b1;
                        csr_write_index  <= index_q;
                        csr_write_data   <= new_value;
                        state_q          <= StWrite;
                    end else begin
                        rsp_valid   <= 1'b1;
                        rsp_source  <= src_q;
                        rsp_rdata   <= csr_read_data;
                        rsp_illegal <= illegal;
                        state_q     <= StResp;
                    end
                end
                StWrite: begin
                    rsp_valid  <= 1'b1;
                    rsp_source <= src_q;
                    rsp_rdata  <= old_q;
                    state_q    <= StResp;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
